mcs4_bus_arbiter: RTL and testbench

MCS4_BUS_ARBITER -- requirements
Module: mcs4_bus_arbiter

---
 rtl/mcs4_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mcs4_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_bus_arbiter.sv
// ============================================================================
//  mcs4_bus_arbiter
//  Phase-tracked owner selection and contention/violation monitor for the
//  shared 4-bit MCS-4 data bus.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mcs4_bus_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             sysclk,
  input  logic             poc_pad,
  input  logic             clk2_pad,
  input  logic             sync_pad,
  input  logic [3:0]       req_dir,
  input  logic [15:0]      req_data,
  input  logic             err_clear,
  output logic             bus_dir,
  output logic [3:0]       bus_data,
  output logic [3:0]       grant,
  output logic [2:0]       phase,
  output logic             locked,
  output logic             contention,
  output logic             violation,
  output logic             sync_err,
  output logic [CNT_W-1:0] cont_count
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  phase_e           phase_q, phase_d;
  logic             locked_q, locked_d;
  logic             clk2_q, clk2_d;
  logic [3:0]       grant_q, grant_d;
  logic             bus_dir_q, bus_dir_d;
  logic [3:0]       bus_data_q, bus_data_d;
  logic             contention_q, contention_d;
  logic             violation_q, violation_d;
  logic             sync_err_q, sync_err_d;
  logic [CNT_W-1:0] cont_count_q, cont_count_d;

  logic             adv;
  logic [3:0]       eligible;
  logic [3:0]       req_e;
  logic             multi;
  logic             ineligible;
  logic             sync_bad;

  always_comb begin
    adv = clk2_pad & ~clk2_q;

    eligible = 4'b0000;
    if (locked_q) begin
      case (phase_q)
        PH_M1, PH_M2: eligible = 4'b0110;
        PH_X2, PH_X3: eligible = 4'b1111;
        default:      eligible = 4'b0001;
      endcase
    end

    req_e      = req_dir & eligible;
    multi      = (req_e & (req_e - 4'd1)) != 4'd0;
    ineligible = (req_dir & ~eligible) != 4'd0;
    // SYNC must be seen exactly on the advance out of X3
    sync_bad   = adv & locked_q & (sync_pad != (phase_q == PH_X3));
  end

  always_comb begin
    clk2_d       = clk2_pad;
    phase_d      = phase_q;
    locked_d     = locked_q;
    grant_d      = 4'b0000;
    bus_data_d   = 4'h0;
    bus_dir_d    = req_e != 4'd0;
    contention_d = contention_q | multi;
    violation_d  = violation_q | ineligible;
    sync_err_d   = sync_err_q | sync_bad;
    cont_count_d = cont_count_q;

    if (req_e[0]) begin
      grant_d    = 4'b0001;
      bus_data_d = req_data[3:0];
    end else if (req_e[1]) begin
      grant_d    = 4'b0010;
      bus_data_d = req_data[7:4];
    end else if (req_e[2]) begin
      grant_d    = 4'b0100;
      bus_data_d = req_data[11:8];
    end else if (req_e[3]) begin
      grant_d    = 4'b1000;
      bus_data_d = req_data[15:12];
    end

    if (multi && cont_count_q != CNT_MAX) begin
      cont_count_d = cont_count_q + 1'b1;
    end

    if (err_clear) begin
      contention_d = 1'b0;
      violation_d  = 1'b0;
      sync_err_d   = 1'b0;
      cont_count_d = '0;
    end

    if (adv) begin
      if (sync_pad) begin
        phase_d  = PH_A1;
        locked_d = 1'b1;
      end else if (locked_q) begin
        phase_d  = phase_e'(phase_q + 3'd1);
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (poc_pad) begin
      phase_q      <= PH_X3;
      locked_q     <= 1'b0;
      clk2_q       <= 1'b0;
      grant_q      <= 4'b0000;
      bus_dir_q    <= 1'b0;
      bus_data_q   <= 4'h0;
      contention_q <= 1'b0;
      violation_q  <= 1'b0;
      sync_err_q   <= 1'b0;
      cont_count_q <= '0;
    end else begin
      phase_q      <= phase_d;
      locked_q     <= locked_d;
      clk2_q       <= clk2_d;
      grant_q      <= grant_d;
      bus_dir_q    <= bus_dir_d;
      bus_data_q   <= bus_data_d;
      contention_q <= contention_d;
      violation_q  <= violation_d;
      sync_err_q   <= sync_err_d;
      cont_count_q <= cont_count_d;
    end
  end

  assign phase      = phase_q;
  assign locked     = locked_q;
  assign grant      = grant_q;
  assign bus_dir    = bus_dir_q;
  assign bus_data   = bus_data_q;
  assign contention = contention_q;
  assign violation  = violation_q;
  assign sync_err   = sync_err_q;
  assign cont_count = cont_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mcs4_bus_arbiter.sv
// ============================================================================
//  tb_mcs4_bus_arbiter
//  Directed scenarios plus randomized traffic checked against a bench model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mcs4_bus_arbiter;

  logic        sysclk;
  logic        poc_pad;
  logic        clk2_pad;
  logic        sync_pad;
  logic [3:0]  req_dir;
  logic [15:0] req_data;
  logic        err_clear;

  logic        bus_dir, bus_dir2;
  logic [3:0]  bus_data, bus_data2;
  logic [3:0]  grant, grant2;
  logic [2:0]  phase, phase2;
  logic        locked, locked2;
  logic        contention, contention2;
  logic        violation, violation2;
  logic        sync_err, sync_err2;
  logic [7:0]  cont_count;
  logic [1:0]  cont_count2;

  int n_vec  = 0;
  int n_miss = 0;

  mcs4_bus_arbiter #(.CNT_W(8)) u_dut (
    .sysclk(sysclk), .poc_pad(poc_pad), .clk2_pad(clk2_pad), .sync_pad(sync_pad),
    .req_dir(req_dir), .req_data(req_data), .err_clear(err_clear),
    .bus_dir(bus_dir), .bus_data(bus_data), .grant(grant), .phase(phase),
    .locked(locked), .contention(contention), .violation(violation),
    .sync_err(sync_err), .cont_count(cont_count)
  );

  mcs4_bus_arbiter #(.CNT_W(2)) u_dut2 (
    .sysclk(sysclk), .poc_pad(poc_pad), .clk2_pad(clk2_pad), .sync_pad(sync_pad),
    .req_dir(req_dir), .req_data(req_data), .err_clear(err_clear),
    .bus_dir(bus_dir2), .bus_data(bus_data2), .grant(grant2), .phase(phase2),
    .locked(locked2), .contention(contention2), .violation(violation2),
    .sync_err(sync_err2), .cont_count(cont_count2)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_valid = 1'b0;
  int       m_phase;
  bit       m_locked;
  bit       m_clk2;
  bit [3:0] m_grant;
  bit       m_dir;
  bit [3:0] m_data;
  bit       m_cont, m_viol, m_serr;
  int       m_cnt8, m_cnt2;

  function automatic bit [3:0] elig_of(input int ph, input bit lk);
    if (!lk) return 4'b0000;
    if (ph == 3 || ph == 4) return 4'b0110;
    if (ph == 6 || ph == 7) return 4'b1111;
    return 4'b0001;
  endfunction

  always @(posedge sysclk) begin
    if (poc_pad) begin
      m_valid = 1'b1;
      m_phase = 7; m_locked = 0; m_clk2 = 0;
      m_grant = 0; m_dir = 0; m_data = 0;
      m_cont = 0; m_viol = 0; m_serr = 0;
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (m_valid) begin
      bit [3:0] el, re;
      bit       adv, bad;
      int       win;
      el  = elig_of(m_phase, m_locked);
      re  = req_dir & el;
      win = -1;
      for (int k = 0; k < 4; k++) if (re[k] && win < 0) win = k;
      m_grant = (win < 0) ? 4'b0000 : 4'(1 << win);
      m_data  = (win < 0) ? 4'h0 : req_data[4*win +: 4];
      m_dir   = (win >= 0);
      adv = clk2_pad && !m_clk2;
      bad = adv && m_locked && ((m_phase == 7) != sync_pad);
      if (err_clear) begin
        m_cont = 0; m_viol = 0; m_serr = 0; m_cnt8 = 0; m_cnt2 = 0;
      end else begin
        if ($countones(re) > 1) begin
          m_cont = 1;
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        if ((req_dir & ~el) != 0) m_viol = 1;
        if (bad) m_serr = 1;
      end
      if (adv) begin
        if (sync_pad) begin
          m_phase = 0; m_locked = 1;
        end else if (m_locked) begin
          m_phase = (m_phase + 1) % 8;
        end
      end
      m_clk2 = clk2_pad;
    end
  end

  always @(negedge sysclk) begin
    if (m_valid) begin
      chk("grant",       32'(grant),       32'(m_grant));
      chk("bus_dir",     32'(bus_dir),     32'(m_dir));
      chk("bus_data",    32'(bus_data),    32'(m_data));
      chk("phase",       32'(phase),       32'(m_phase));
      chk("locked",      32'(locked),      32'(m_locked));
      chk("contention",  32'(contention),  32'(m_cont));
      chk("violation",   32'(violation),   32'(m_viol));
      chk("sync_err",    32'(sync_err),    32'(m_serr));
      chk("cont_count",  32'(cont_count),  32'(m_cnt8));
      chk("cont_count2", 32'(cont_count2), 32'(m_cnt2));
      chk("grant2",      32'(grant2),      32'(m_grant));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge sysclk);
    #2;
  endtask

  task automatic adv_pulse(input bit s);
    clk2_pad = 1'b1; sync_pad = s;
    tick();
    clk2_pad = 1'b0; sync_pad = 1'b0;
    tick();
  endtask

  initial begin
    poc_pad = 1'b1; clk2_pad = 1'b0; sync_pad = 1'b0;
    req_dir = 4'b0000; req_data = 16'h0000; err_clear = 1'b0;
    tick(); tick();
    chk("rst_phase",  32'(phase),  32'd7);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_grant",  32'(grant),  32'd0);
    poc_pad = 1'b0;

    // lock acquisition with CPU requesting throughout
    req_dir = 4'b0001; req_data = 16'h000C;
    for (int i = 0; i < 3; i++) begin
      adv_pulse(1'b0);
      chk("prelock_locked", 32'(locked),  32'd0);
      chk("prelock_phase",  32'(phase),   32'd7);
      chk("prelock_busdir", 32'(bus_dir), 32'd0);
    end
    adv_pulse(1'b1);
    chk("lock_locked", 32'(locked), 32'd1);
    chk("lock_phase",  32'(phase),  32'd0);
    req_dir = 4'b0000;
    err_clear = 1'b1; tick(); err_clear = 1'b0;

    // phase walk, correct SYNC then missing SYNC
    for (int i = 1; i <= 8; i++) begin
      adv_pulse(i == 8);
      chk("walk_phase", 32'(phase), 32'(i % 8));
    end
    chk("walk_syncerr", 32'(sync_err), 32'd0);
    for (int i = 1; i <= 8; i++) adv_pulse(1'b0);
    chk("wrap_phase",   32'(phase),    32'd0);
    chk("wrap_syncerr", 32'(sync_err), 32'd1);
    err_clear = 1'b1; tick(); err_clear = 1'b0;

    // ownership in M1
    for (int i = 0; i < 3; i++) adv_pulse(1'b0);
    req_dir = 4'b0011; req_data = 16'h005A;
    tick();
    chk("m1_grant",      32'(grant),      32'b0010);
    chk("m1_busdata",    32'(bus_data),   32'h5);
    chk("m1_violation",  32'(violation),  32'd1);
    chk("m1_contention", 32'(contention), 32'd0);
    req_dir = 4'b0000;
    err_clear = 1'b1; tick(); err_clear = 1'b0;

    // contention in X2, including 2-bit saturation
    for (int i = 0; i < 3; i++) adv_pulse(1'b0);
    req_dir = 4'b1001; req_data = 16'h7003;
    tick(); tick(); tick();
    chk("x2_grant",  32'(grant),       32'b0001);
    chk("x2_cnt8",   32'(cont_count),  32'd3);
    chk("x2_cnt2",   32'(cont_count2), 32'd3);
    tick(); tick();
    chk("x2_cnt8_5", 32'(cont_count),  32'd5);
    chk("x2_sat2",   32'(cont_count2), 32'd3);

    // clear wins over a simultaneous new contention
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    chk("clr_cont",  32'(contention), 32'd0);
    chk("clr_viol",  32'(violation),  32'd0);
    chk("clr_serr",  32'(sync_err),   32'd0);
    chk("clr_cnt",   32'(cont_count), 32'd0);
    req_dir = 4'b0000;

    // reset while locked in X3
    adv_pulse(1'b0);
    chk("x3_phase", 32'(phase), 32'd7);
    req_dir = 4'b1111; tick();
    chk("x3_busdir", 32'(bus_dir), 32'd1);
    poc_pad = 1'b1; tick(); poc_pad = 1'b0;
    chk("poc_phase",  32'(phase),   32'd7);
    chk("poc_locked", 32'(locked),  32'd0);
    chk("poc_busdir", 32'(bus_dir), 32'd0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 1) == 0) clk2_pad = ~clk2_pad;
      if (m_locked && m_phase == 7) sync_pad = ($urandom_range(0, 9) != 0);
      else if (!m_locked)           sync_pad = ($urandom_range(0, 4) == 0);
      else                          sync_pad = ($urandom_range(0, 29) == 0);
      req_dir   = 4'($urandom);
      req_data  = 16'($urandom);
      err_clear = ($urandom_range(0, 39) == 0);
      poc_pad   = ($urandom_range(0, 299) == 0);
      tick();
    end
    poc_pad = 1'b0; err_clear = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
